adc_serial_rx: RTL and testbench

Serial ADC receive stage fed by the SCLK divider's `s_clk` (clk/72, 36-cycle half period). It frames conversions with an active-low chip select, shifts in 16 serial bits per conversion on `s_clk` rising edges, and presents a 12-bit parallel sample with a one-cycle valid strobe. It sits between the SCLK divider and the audio sample-processing logic, running entirely in the `clk` domain.

---
 rtl/adc_serial_rx.sv | 131 +++++++++++++
 tb/tb_adc_serial_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: frames serial ADC conversions with an active-low chip select,
// shifts CONV_BITS bits in on s_clk rising edges and presents the low DATA_BITS
// bits as a parallel sample with a one-clk valid strobe. s_clk is a register
// output in the clk domain, so edges are found by comparing it with a delayed
// copy rather than by synchronizing it.
module adc_serial_rx #(
   parameter int unsigned CONV_BITS  = 16,
   parameter int unsigned QUIET_BITS = 16,
   parameter int unsigned DATA_BITS  = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_clk,
   input  logic                 en,
   input  logic                 sdata,
   output logic                 cs_n,
   output logic [DATA_BITS-1:0] sample,
   output logic                 data_valid,
   output logic                 frame_err
);

   localparam int unsigned MAX_BITS = (CONV_BITS > QUIET_BITS) ? CONV_BITS : QUIET_BITS;
   localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

   localparam logic [CNT_W-1:0] CONV_DONE  = CNT_W'(CONV_BITS);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      QUIET = 2'd2
   } state_t;

   state_t                 state_q;
   logic                   s_q;
   logic [CONV_BITS-1:0]   shreg_q;
   logic [CONV_BITS-1:0]   shreg_d;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic                   cs_n_q;
   logic [DATA_BITS-1:0]   sample_q;
   logic                   data_valid_q;
   logic                   frame_err_q;
   logic                   rise;
   logic                   fall;

   // Delayed copy of s_clk for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_q <= 1'b0;
      end else begin
         s_q <= s_clk;
      end
   end

   // Edge strobes and the next shift-register value.
   always_comb begin
      rise    = s_clk & ~s_q;
      fall    = ~s_clk & s_q;
      shreg_d = {shreg_q[CONV_BITS-2:0], sdata};
   end

   // Frame sequencer: chip select window, bit capture and sample hand-off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         cs_n_q       <= 1'b1;
         sample_q     <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               cs_n_q <= 1'b1;
               if (fall && en) begin
                  cs_n_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= CONV;
               end
            end
            CONV: begin
               if (rise) begin
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_q + CNT_ONE;
               end else if (fall) begin
                  if (bit_cnt_q == CONV_DONE) begin
                     cs_n_q       <= 1'b1;
                     sample_q     <= shreg_q[DATA_BITS-1:0];
                     frame_err_q  <= |shreg_q[CONV_BITS-1:DATA_BITS];
                     data_valid_q <= 1'b1;
                     bit_cnt_q    <= '0;
                     state_q      <= QUIET;
                  end else begin
                     cs_n_q <= 1'b0;
                  end
               end
            end
            QUIET: begin
               if (fall) begin
                  if (bit_cnt_q == QUIET_LAST) begin
                     // Back-to-back frames skip IDLE so the frame period stays exact.
                     if (en) begin
                        cs_n_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= CONV;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                        state_q   <= IDLE;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               cs_n_q  <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cs_n       = cs_n_q;
   assign sample     = sample_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: an ADC model serves 16-bit words MSB first while a
// monitor compares each completed sample, error flag and frame timing against
// values derived from the words sent and the frame arithmetic.
`timescale 1ns/1ps
module tb_adc_serial_rx;

   logic        clk;
   logic        reset;
   logic        s_clk;
   logic        en;
   logic        sdata;
   logic        cs_n;
   logic [11:0] sample;
   logic        data_valid;
   logic        frame_err;

   int total = 0;
   int bad   = 0;

   logic [15:0] stimq[$];
   logic [15:0] expq[$];

   int cyc          = 0;
   int vcount       = 0;
   int cs_low_cyc   = 0;
   int fall_cyc     = 0;
   bit fall_ok      = 0;
   int last_v       = 0;
   bit last_v_ok    = 0;
   bit cont_chk     = 0;
   logic prev_cs    = 1'b1;
   logic prev_dv    = 1'b0;

   adc_serial_rx #(
      .CONV_BITS (16),
      .QUIET_BITS(16),
      .DATA_BITS (12)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_clk     (s_clk),
      .en        (en),
      .sdata     (sdata),
      .cs_n      (cs_n),
      .sample    (sample),
      .data_valid(data_valid),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // s_clk behaves like a divider register: toggles 2ns after every 36th clk edge.
   initial begin
      s_clk = 1'b0;
      @(posedge clk);
      #2;
      forever #360 s_clk = ~s_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ADC model: one word per chip-select window, MSB presented at cs_n fall,
   // following bits presented on each s_clk falling edge.
   initial begin
      logic [15:0] w;
      int idx;
      sdata = 1'b0;
      forever begin
         @(negedge cs_n);
         if (stimq.size() != 0) w = stimq.pop_front();
         else w = 16'($urandom);
         expq.push_back(w);
         idx   = 15;
         sdata = w[15];
         while (1) begin
            @(negedge s_clk or posedge cs_n);
            if (cs_n) break;
            if (idx > 0) begin
               idx--;
               sdata = w[idx];
            end
         end
      end
   end

   // Monitor: sample outputs 1ns after each clk edge.
   always @(posedge clk) begin
      logic [15:0] w;
      #1;
      cyc++;
      if (reset) begin
         fall_ok   = 0;
         last_v_ok = 0;
         prev_cs   = 1'b1;
         prev_dv   = 1'b0;
      end else begin
         if (prev_cs && !cs_n) begin
            fall_cyc = cyc;
            fall_ok  = 1;
         end
         if (!prev_cs && cs_n && fall_ok) begin
            check("cs_low_len", 32'(cyc - fall_cyc), 32'd1152);
            fall_ok = 0;
         end
         if (data_valid) begin
            vcount++;
            check("dv_width", {31'd0, prev_dv}, 32'd0);
            check("cs_rise_with_dv", {30'd0, prev_cs, cs_n}, 32'd1);
            if (expq.size() == 0) begin
               check("unexpected_dv", 32'd1, 32'd0);
            end else begin
               w = expq.pop_front();
               check("sample", {20'd0, sample}, {20'd0, w[11:0]});
               check("frame_err", {31'd0, frame_err}, {31'd0, (w[15:12] != 4'd0)});
            end
            if (cont_chk && last_v_ok) check("dv_spacing", 32'(cyc - last_v), 32'd2304);
            last_v    = cyc;
            last_v_ok = 1;
         end
         if (!cs_n) cs_low_cyc++;
         prev_cs = cs_n;
         prev_dv = data_valid;
      end
   end

   task automatic wait_valid(input int n);
      int start;
      int t;
      start = vcount;
      t     = 0;
      while (vcount < start + n && t < 2304 * (n + 2)) begin
         @(posedge clk);
         t++;
      end
      #2;
      check("valid_count", 32'(vcount - start), 32'(n));
   endtask

   task automatic wait_cs_low();
      int t;
      t = 0;
      while (cs_n && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("cs_fall_seen", {31'd0, cs_n}, 32'd0);
   endtask

   initial begin
      int v0;
      int c0;
      logic [15:0] w;

      reset = 1'b1;
      en    = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_cs_n", {31'd0, cs_n}, 32'd1);
      check("rst_sample", {20'd0, sample}, 32'd0);
      check("rst_dv", {31'd0, data_valid}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      reset = 1'b0;

      // Disabled: 10 s_clk periods with no activity.
      v0 = vcount;
      c0 = cs_low_cyc;
      repeat (720) @(posedge clk);
      #2;
      check("idle_cs_low_cycles", 32'(cs_low_cyc - c0), 32'd0);
      check("idle_valids", 32'(vcount - v0), 32'd0);
      check("idle_sample", {20'd0, sample}, 32'd0);

      // Single frame 0x0ABC.
      stimq.push_back(16'h0ABC);
      en = 1'b1;
      wait_cs_low();
      en = 1'b0;
      wait_valid(1);
      check("abc_sample", {20'd0, sample}, 32'h0ABC);
      check("abc_ferr", {31'd0, frame_err}, 32'd0);

      // Single frame 0x8123 with a nonzero leading bit.
      stimq.push_back(16'h8123);
      en = 1'b1;
      wait_cs_low();
      en = 1'b0;
      wait_valid(1);
      check("x123_sample", {20'd0, sample}, 32'h0123);
      check("x123_ferr", {31'd0, frame_err}, 32'd1);

      // Continuous: fixed corner words then random words, exact frame period.
      stimq.push_back(16'h0001);
      stimq.push_back(16'h0FFF);
      stimq.push_back(16'h0000);
      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 1) == 1) w[15:12] = 4'd0;
         stimq.push_back(w);
      end
      last_v_ok = 0;
      cont_chk  = 1;
      en        = 1'b1;
      wait_valid(9);
      en        = 1'b0;
      cont_chk  = 0;

      // en dropped at the 5th rise: frame completes, then stays idle.
      stimq.push_back(16'h3456);
      en = 1'b1;
      wait_cs_low();
      repeat (5) @(posedge s_clk);
      en = 1'b0;
      wait_valid(1);
      check("drop_sample", {20'd0, sample}, 32'h0456);
      v0 = vcount;
      c0 = cs_low_cyc;
      repeat (2880) @(posedge clk);
      #2;
      check("drop_no_valid", 32'(vcount - v0), 32'd0);
      check("drop_cs_high", 32'(cs_low_cyc - c0), 32'd0);

      // Reset at the 8th rise, then restart on the next s_clk fall.
      stimq.push_back(16'h0BEE);
      en = 1'b1;
      wait_cs_low();
      repeat (8) @(posedge s_clk);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
      check("midrst_sample", {20'd0, sample}, 32'd0);
      check("midrst_dv", {31'd0, data_valid}, 32'd0);
      check("midrst_ferr", {31'd0, frame_err}, 32'd0);
      expq.delete();
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      stimq.push_back(16'h0D5A);
      @(negedge s_clk);
      @(posedge clk);
      #1;
      check("restart_cs_n", {31'd0, cs_n}, 32'd0);
      en = 1'b0;
      wait_valid(1);
      check("restart_sample", {20'd0, sample}, 32'h0D5A);
      check("restart_ferr", {31'd0, frame_err}, 32'd0);

      repeat (10) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
